// File: rtl/team11_uart_pkg.sv
// Shared UART definitions for the team-11 serial path (shift_divide, shift_collect, baud generator).
package team11_uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/shift_collect.sv
// UART receive deserializer: start detection, LSB-first assembly, stop check and a
// valid/ready holding register with framing-error and overrun pulses.
module shift_collect
    import team11_uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 enable_s,
    input  logic                 bit_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] data_received,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t             state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  framing_err_q, framing_err_d;
    logic                  overrun_q, overrun_d;

    logic frame_good_c;
    logic frame_bad_c;
    logic load_c;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_bit_in (
        .clk  (clk),
        .nrst (nrst),
        .d    (bit_in),
        .q    (rx_s)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame sequencing; every transition is qualified by the sample strobe.
    always_comb begin
        state_d = state_q;
        if (enable_s) begin
            case (state_q)
                IDLE:      if (!rx_s) state_d = START;
                START:     if (tick_cnt_q == TICK_MID) state_d = rx_s ? IDLE : DATA;
                DATA:      if (tick_cnt_q == TICK_LAST && bit_cnt_q == BIT_LAST) state_d = STOP;
                STOP:      if (tick_cnt_q == TICK_LAST) state_d = rx_s ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (rx_s) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_good_c = 1'b0;
        frame_bad_c  = 1'b0;
        if (enable_s) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) tick_cnt_d = '0;
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        frame_good_c = rx_s;
                        frame_bad_c  = !rx_s;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Holding register: a completed byte loads only if the slot is free or being drained now.
    always_comb begin
        load_c        = frame_good_c && (!rx_valid_q || rx_ready);
        data_d        = load_c ? shift_q : data_q;
        rx_valid_d    = rx_valid_q;
        if (load_c) begin
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        overrun_d     = frame_good_c && rx_valid_q && !rx_ready;
        framing_err_d = frame_bad_c;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_received = data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_err   = framing_err_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_shift_collect.sv
// Self-checking bench for shift_collect: directed frames plus randomized frames against a
// per-frame holding-register model.
module tb_shift_collect;

    localparam int unsigned OS = 4;
    localparam int unsigned DB = 8;
    // Line edge to visible result: 3 clk of sync + detection, half a bit to mid-start, 9 bits.
    localparam int unsigned DONE_LAT = 3 + OS / 2 + (DB + 1) * OS;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          enable_s = 1'b1;
    logic          bit_in = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] data_received;
    logic          rx_valid;
    logic          framing_err;
    logic          overrun;

    shift_collect #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .enable_s      (enable_s),
        .bit_in        (bit_in),
        .rx_ready      (rx_ready),
        .data_received (data_received),
        .rx_valid      (rx_valid),
        .framing_err   (framing_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled mid-cycle.
    int   rise_cnt = 0, fe_cnt = 0, ov_cnt = 0, long_pulse_cnt = 0;
    int   last_rise_cyc = -1, last_fe_cyc = -1, last_ov_cyc = -1;
    logic prev_valid = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (framing_err) begin
            if (prev_fe) long_pulse_cnt++;
            else begin fe_cnt++; last_fe_cyc = cyc; end
        end
        if (overrun) begin
            if (prev_ov) long_pulse_cnt++;
            else begin ov_cnt++; last_ov_cyc = cyc; end
        end
        prev_valid = rx_valid;
        prev_fe    = framing_err;
        prev_ov    = overrun;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic half_rate = 1'b0;

    task automatic tick1();
        @(negedge clk);
        #1;
        if (half_rate) enable_s = ~enable_s;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int clks_per_bit,
                              output int start_cyc);
        logic [9:0] bits;
        bits      = {stop, data, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            bit_in = bits[i];
            repeat (clks_per_bit) tick1();
        end
        bit_in = 1'b1;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick1();
        rx_ready = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int s, s1, s2;
        int exp_rise, exp_fe, exp_ov;
        logic       model_valid;
        logic [7:0] model_data;
        logic [7:0] d;
        logic       good;
        logic [9:0] rst_bits;

        #2 nrst = 1'b0;
        repeat (3) tick1();
        check_eq("reset_data", 32'(data_received), 32'h0);
        check_eq("reset_valid", 32'(rx_valid), 32'h0);
        check_eq("reset_ferr", 32'(framing_err), 32'h0);
        check_eq("reset_ovr", 32'(overrun), 32'h0);
        nrst = 1'b1;

        // Idle line
        repeat (50) tick1();
        check_eq("idle_rise", 32'(rise_cnt), 32'd0);
        check_eq("idle_valid", 32'(rx_valid), 32'h0);
        check_eq("idle_data", 32'(data_received), 32'h0);
        exp_rise = 0; exp_fe = 0; exp_ov = 0;

        // 0xD3, held until consumed
        send_frame(8'hD3, 1'b1, OS, s);
        tick1();
        exp_rise++;
        check_eq("d3_data", 32'(data_received), 32'hD3);
        check_eq("d3_valid", 32'(rx_valid), 32'h1);
        check_eq("d3_latency", 32'(last_rise_cyc), 32'(s + int'(DONE_LAT)));
        repeat (10) tick1();
        check_eq("d3_hold", 32'(rx_valid), 32'h1);
        consume();
        check_eq("d3_drain_valid", 32'(rx_valid), 32'h0);
        check_eq("d3_drain_data", 32'(data_received), 32'hD3);

        // One-clock glitch
        bit_in = 1'b0;
        tick1();
        bit_in = 1'b1;
        repeat (30) tick1();
        check_eq("glitch_rise", 32'(rise_cnt), 32'(exp_rise));
        check_eq("glitch_ferr", 32'(fe_cnt), 32'(exp_fe));

        // Bad stop then break, then 0xA5
        send_frame(8'h55, 1'b0, OS, s);
        bit_in = 1'b0;
        tick1();
        exp_fe++;
        check_eq("break_ferr", 32'(fe_cnt), 32'(exp_fe));
        check_eq("break_ferr_cyc", 32'(last_fe_cyc), 32'(s + int'(DONE_LAT)));
        repeat (19) tick1();
        bit_in = 1'b1;
        repeat (8) tick1();
        check_eq("break_valid", 32'(rx_valid), 32'h0);
        check_eq("break_ferr_once", 32'(fe_cnt), 32'(exp_fe));
        send_frame(8'hA5, 1'b1, OS, s);
        tick1();
        exp_rise++;
        check_eq("a5_data", 32'(data_received), 32'hA5);
        check_eq("a5_valid", 32'(rx_valid), 32'h1);
        consume();

        // Back-to-back, no consumer: second byte dropped
        send_frame(8'h01, 1'b1, OS, s1);
        send_frame(8'h02, 1'b1, OS, s2);
        tick1();
        exp_rise++; exp_ov++;
        check_eq("ovr_data", 32'(data_received), 32'h01);
        check_eq("ovr_valid", 32'(rx_valid), 32'h1);
        check_eq("ovr_count", 32'(ov_cnt), 32'(exp_ov));
        check_eq("ovr_cyc", 32'(last_ov_cyc), 32'(s2 + int'(DONE_LAT)));
        repeat (5) tick1();
        consume();
        check_eq("ovr_drain", 32'(rx_valid), 32'h0);

        // Back-to-back with drain on the second completion edge
        fork
            begin
                send_frame(8'h01, 1'b1, OS, s1);
                send_frame(8'h02, 1'b1, OS, s2);
            end
            begin
                repeat (80) tick1();
                rx_ready = 1'b1;
                tick1();
                rx_ready = 1'b0;
            end
        join
        exp_rise++;
        check_eq("swap_data", 32'(data_received), 32'h02);
        check_eq("swap_valid", 32'(rx_valid), 32'h1);
        check_eq("swap_ovr", 32'(ov_cnt), 32'(exp_ov));
        check_eq("swap_rise", 32'(rise_cnt), 32'(exp_rise));

        // Reset during bit 4, byte 0x02 still held beforehand
        rst_bits = {1'b1, 8'h96, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bit_in = rst_bits[i];
            repeat (OS) tick1();
        end
        bit_in = rst_bits[5];
        repeat (2) tick1();
        nrst = 1'b0;
        tick1();
        check_eq("mrst_data", 32'(data_received), 32'h0);
        check_eq("mrst_valid", 32'(rx_valid), 32'h0);
        bit_in = 1'b1;
        repeat (3) tick1();
        nrst = 1'b1;
        repeat (12) tick1();
        send_frame(8'h3C, 1'b1, OS, s);
        tick1();
        exp_rise++;
        check_eq("3c_data", 32'(data_received), 32'h3C);
        check_eq("3c_latency", 32'(last_rise_cyc), 32'(s + int'(DONE_LAT)));
        check_eq("3c_ferr", 32'(fe_cnt), 32'(exp_fe));
        check_eq("3c_ovr", 32'(ov_cnt), 32'(exp_ov));
        check_eq("3c_rise", 32'(rise_cnt), 32'(exp_rise));
        consume();

        // Strobe every other clock: counters must hold between strobes
        half_rate = 1'b1;
        send_frame(8'hC6, 1'b1, 2 * OS, s);
        repeat (12) tick1();
        half_rate = 1'b0;
        enable_s  = 1'b1;
        exp_rise++;
        check_eq("half_data", 32'(data_received), 32'hC6);
        check_eq("half_valid", 32'(rx_valid), 32'h1);
        consume();
        repeat (4) tick1();

        // Randomized frames against a per-frame holding-register model
        model_valid = 1'b0;
        model_data  = 8'hC6;
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(d, good, OS, s);
            if (!good) bit_in = 1'b0;
            tick1();
            if (good) begin
                if (!model_valid) begin
                    model_valid = 1'b1;
                    model_data  = d;
                    exp_rise++;
                    check_eq("rnd_rise_cyc", 32'(last_rise_cyc), 32'(s + int'(DONE_LAT)));
                end else begin
                    exp_ov++;
                    check_eq("rnd_ovr_cyc", 32'(last_ov_cyc), 32'(s + int'(DONE_LAT)));
                end
            end else begin
                exp_fe++;
                check_eq("rnd_ferr_cyc", 32'(last_fe_cyc), 32'(s + int'(DONE_LAT)));
            end
            check_eq("rnd_data", 32'(data_received), 32'(model_data));
            check_eq("rnd_valid", 32'(rx_valid), 32'(model_valid));
            check_eq("rnd_ferr", 32'(fe_cnt), 32'(exp_fe));
            check_eq("rnd_ovr", 32'(ov_cnt), 32'(exp_ov));
            if (!good) begin
                repeat ($urandom_range(0, 6)) tick1();
                bit_in = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) begin
                consume();
                model_valid = 1'b0;
            end
            repeat ($urandom_range(2, 6)) tick1();
        end
        check_eq("rnd_rise_total", 32'(rise_cnt), 32'(exp_rise));
        check_eq("pulse_width", 32'(long_pulse_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_collect.md
# shift_collect

UART-style receive deserializer and the downstream counterpart of the `shift_divide` transmit shifter. It oversamples a serial line against a strobe, detects the start bit, and assembles 8 data bits LSB-first. It checks the stop bit and presents the byte through a valid/ready holding register. It reports framing errors and overruns as one-cycle pulses to the team-11 peripheral control logic.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `enable_s` strobes per bit period; even, ≥4.
- `DATA_BITS`, default 8: payload bits per frame.

Ports:
- `clk`  in  1: system clock.
- `nrst`  in  1: asynchronous, active-low reset.
- `enable_s`  in  1: one-cycle sample strobe at `OVERSAMPLE`×baud.
- `bit_in`  in  1: serial line; idle high; asynchronous to `clk`.
- `rx_ready`  in  1: consumer accepts byte when high with `rx_valid`.
- `data_received`  out  DATA_BITS: held received byte.
- `rx_valid`  out  1: `data_received` holds an unconsumed byte.
- `framing_err`  out  1: one-cycle pulse; stop bit sampled low.
- `overrun`  out  1: one-cycle pulse; completed byte dropped because holding register full.

## Operation
- `bit_in` passes through a 2-flop synchronizer reset to 1; the FSM uses only the synchronized value `rx_s`.
- `tick_cnt`, $clog2(OVERSAMPLE) bits, and `bit_cnt`, $clog2(DATA_BITS+1) bits, advance only on cycles with `enable_s`=1. With `enable_s`=0 all state holds.
- IDLE: on tick with `rx_s`=0 → START, `tick_cnt`=0.
- START: on tick with `tick_cnt`==OVERSAMPLE/2−1, sample `rx_s`:
  - `rx_s`=0: go to DATA, clear `tick_cnt` and `bit_cnt`.
  - `rx_s`=1: false start, go to IDLE.
  - Otherwise `tick_cnt`++.
- DATA: on tick with `tick_cnt`==OVERSAMPLE−1, shift `rx_s` into the MSB of the shift register (shift right, so LSB first), `bit_cnt`++, `tick_cnt`=0. After the DATA_BITS-th sample → STOP.
- STOP: on tick with `tick_cnt`==OVERSAMPLE−1, sample `rx_s`:
  - `rx_s`=1: frame good → IDLE.
  - `rx_s`=0: pulse `framing_err`, discard byte → WAIT_HIGH.
- WAIT_HIGH: stay until a tick with `rx_s`=1, then → IDLE. This blocks false restarts during a break.
- Good frame, holding register empty, or consumed in the same cycle: load `data_received`; `rx_valid`=1.
- Good frame while `rx_valid`=1 and `rx_ready`=0: old byte kept, new byte dropped, pulse `overrun`.
- `rx_valid` && `rx_ready` with no simultaneous load: `rx_valid`→0; `data_received` retains its value.

## Timing
- Reset values: state IDLE, counters 0, shift register 0, `data_received`=0, `rx_valid`=0, `framing_err`=0, `overrun`=0, synchronizer flops=1.
- Synchronizer latency: 2 clk.
- Good frame: `rx_valid` rises on the clock edge of the stop-bit mid-sample tick, visible the following cycle.
- End-to-end: line edge to `rx_valid` ≈ 9.5 bit periods + 2 clk + up to 1 tick of detection jitter.
- `framing_err` and `overrun` are high for exactly one clk, at the same edge a good frame would have loaded.
- Handshake: transfer occurs on any edge with `rx_valid`&&`rx_ready`. `rx_ready` is ignored when `rx_valid`=0.
- Reset asserted mid-frame: immediate return to IDLE with outputs at reset values. The partial byte is lost, and no pulse is generated on release.

## Structure
- Shared package `team11_uart_pkg`:
  - state enum `rx_state_t` (IDLE, START, DATA, STOP, WAIT_HIGH);
  - constants `UART_DATA_BITS`=8 and `UART_OVERSAMPLE`=16, also used by `shift_divide` and the baud generator.
- Sub-module `sync_2ff`: parameterized reset value, instanced for `bit_in`.
- All other logic lives in `shift_collect`: FSM, counters, shift register, holding register.

## Test plan
All scenarios use OVERSAMPLE=4, `enable_s` every cycle, and 4-clk bit periods.
- Reset, `bit_in`=1 for 50 clk → all outputs 0, `rx_valid` never rises.
- Frame for 0xD3 (start 0, bits 1,1,0,0,1,0,1,1, stop 1), `rx_ready`=0 → `data_received`=0xD3, `rx_valid`=1 held. Then `rx_ready`=1 for 1 clk → `rx_valid`=0.
- Low glitch of 1 clk on idle line → FSM returns to IDLE, no `rx_valid`, no `framing_err`.
- Frame 0x55 with stop bit 0, then line held low 20 clk, then high → one `framing_err` pulse, `rx_valid` stays 0, next frame 0xA5 received correctly.
- Frames 0x01 then 0x02 back-to-back, `rx_ready`=0 → `data_received`=0x01, one `overrun` pulse at second stop.
- Same two frames with `rx_ready` pulsed at the second-frame completion edge → `data_received`=0x02, `rx_valid` stays 1, no `overrun`.
- `nrst` low during bit 4 of a frame, then a fresh 0x3C frame → only 0x3C delivered, no error pulses.
